// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between the scan sequencer and its surroundings: register write port,
// scan control, the mux drive/return pair and the tagged result stream.
interface mux_scan_sequencer_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [2:0] chan_mask;
  logic       busy;
  logic [1:0] sel;
  logic       cs;
  logic [7:0] alpha;
  logic [7:0] beta;
  logic [7:0] gamma;
  logic [7:0] mux_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic       out_last;

  modport master (
    input  wr_en, wr_addr, wr_data, start, chan_mask, mux_out, out_ready,
    output busy, sel, cs, alpha, beta, gamma, out_valid, out_data, out_chan, out_last
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, chan_mask, mux_out, out_ready,
    input  busy, sel, cs, alpha, beta, gamma, out_valid, out_data, out_chan, out_last
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Drives the 3-input chip-select mux: holds the channel registers, scans the masked
// channels one at a time and streams each captured mux_out tagged with its channel.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  mux_scan_sequencer_if.master bus
);
  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  state_t           state, state_d;
  logic [7:0]       alpha_q, beta_q, gamma_q;
  logic [2:0]       mask_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q, out_last_q;
  logic [7:0]       out_data_q;
  logic [1:0]       out_chan_q;
  logic             cs_c, busy_c;
  logic             scan_req, settle_done;

  // Lowest enabled channel at or above index lo (0 when none remain).
  function automatic logic [1:0] first_from(input logic [2:0] m, input int lo);
    first_from = 2'd0;
    for (int i = 2; i >= 0; i--)
      if (i >= lo && m[i]) first_from = 2'(i);
  endfunction

  function automatic logic any_from(input logic [2:0] m, input int lo);
    any_from = 1'b0;
    for (int i = 0; i < 3; i++)
      if (i >= lo && m[i]) any_from = 1'b1;
  endfunction

  assign scan_req    = bus.start && (bus.chan_mask != 3'b000);
  assign settle_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (scan_req) state_d = SETTLE;
      SETTLE:  if (settle_done) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = out_last_q ? IDLE : SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_c   = (state == SETTLE);
    busy_c = (state != IDLE);
  end

  // Registers only move on IDLE writes/starts, SETTLE capture and HOLD handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      alpha_q     <= 8'h00;
      beta_q      <= 8'h00;
      gamma_q     <= 8'h00;
      mask_q      <= 3'b000;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_chan_q  <= 2'd0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_en) begin
            case (bus.wr_addr)
              2'd0:    alpha_q <= bus.wr_data;
              2'd1:    beta_q  <= bus.wr_data;
              2'd2:    gamma_q <= bus.wr_data;
              default: ;
            endcase
          end
          if (scan_req) begin
            mask_q <= bus.chan_mask;
            sel_q  <= first_from(bus.chan_mask, 0);
            cnt_q  <= '0;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (settle_done) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.mux_out;
            out_chan_q  <= sel_q;
            out_last_q  <= !any_from(mask_q, int'(sel_q) + 1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (!out_last_q) begin
              sel_q <= first_from(mask_q, int'(sel_q) + 1);
              cnt_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.cs        = cs_c;
  assign bus.sel       = sel_q;
  assign bus.alpha     = alpha_q;
  assign bus.beta      = beta_q;
  assign bus.gamma     = gamma_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (settle 1 and 3) share directed stimulus and
// are checked every cycle against a scan model plus hand-computed beat lists.
module tb_mux_scan_sequencer;
  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [2:0] chan_mask;
  logic       rdy [2];

  logic       o_busy [2], o_cs [2], o_valid [2], o_last [2];
  logic [1:0] o_sel [2], o_chan [2];
  logic [7:0] o_alpha [2], o_beta [2], o_gamma [2], o_data [2];

  int n_tests = 0;
  int n_fail  = 0;

  mux_scan_sequencer_if if1 ();
  mux_scan_sequencer_if if3 ();

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));
  mux_scan_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.master));

  assign if1.wr_en = wr_en;     assign if3.wr_en = wr_en;
  assign if1.wr_addr = wr_addr; assign if3.wr_addr = wr_addr;
  assign if1.wr_data = wr_data; assign if3.wr_data = wr_data;
  assign if1.start = start;     assign if3.start = start;
  assign if1.chan_mask = chan_mask; assign if3.chan_mask = chan_mask;
  assign if1.out_ready = rdy[0];    assign if3.out_ready = rdy[1];

  // The mux itself: selected register while chip-selected, zero otherwise.
  assign if1.mux_out = !if1.cs ? 8'h00 : (if1.sel == 2'd0) ? if1.alpha :
                       (if1.sel == 2'd1) ? if1.beta : (if1.sel == 2'd2) ? if1.gamma : 8'h00;
  assign if3.mux_out = !if3.cs ? 8'h00 : (if3.sel == 2'd0) ? if3.alpha :
                       (if3.sel == 2'd1) ? if3.beta : (if3.sel == 2'd2) ? if3.gamma : 8'h00;

  assign o_busy[0] = if1.busy;   assign o_busy[1] = if3.busy;
  assign o_cs[0] = if1.cs;       assign o_cs[1] = if3.cs;
  assign o_sel[0] = if1.sel;     assign o_sel[1] = if3.sel;
  assign o_alpha[0] = if1.alpha; assign o_alpha[1] = if3.alpha;
  assign o_beta[0] = if1.beta;   assign o_beta[1] = if3.beta;
  assign o_gamma[0] = if1.gamma; assign o_gamma[1] = if3.gamma;
  assign o_valid[0] = if1.out_valid; assign o_valid[1] = if3.out_valid;
  assign o_data[0] = if1.out_data;   assign o_data[1] = if3.out_data;
  assign o_chan[0] = if1.out_chan;   assign o_chan[1] = if3.out_chan;
  assign o_last[0] = if1.out_last;   assign o_last[1] = if3.out_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Scan model: busy scan = current channel + set of channels still to visit.
  int       settle_of [2] = '{1, 3};
  bit       m_busy [2], m_settling [2], m_ov [2], m_ol [2];
  int       m_age [2], m_chan [2], m_od [2], m_oc [2];
  bit [2:0] m_todo [2];
  int       m_reg [2][3];

  function automatic int lowest(input bit [2:0] m);
    for (int i = 0; i < 3; i++) if (m[i]) return i;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          m_busy[k] = 0; m_settling[k] = 0; m_ov[k] = 0; m_ol[k] = 0;
          m_age[k] = 0; m_chan[k] = 0; m_od[k] = 0; m_oc[k] = 0; m_todo[k] = 3'b000;
          for (int r = 0; r < 3; r++) m_reg[k][r] = 0;
        end else if (!m_busy[k]) begin
          if (wr_en && wr_addr != 2'd3) m_reg[k][wr_addr] = int'(wr_data);
          if (start && chan_mask != 3'b000) begin
            m_busy[k] = 1; m_settling[k] = 1; m_age[k] = 0;
            m_chan[k] = lowest(chan_mask);
            m_todo[k] = chan_mask & ~(3'b001 << m_chan[k]);
          end
        end else if (m_settling[k]) begin
          m_age[k]++;
          if (m_age[k] == settle_of[k]) begin
            m_ov[k] = 1; m_od[k] = m_reg[k][m_chan[k]]; m_oc[k] = m_chan[k];
            m_ol[k] = (m_todo[k] == 3'b000); m_settling[k] = 0;
          end
        end else if (rdy[k]) begin
          m_ov[k] = 0;
          if (m_ol[k]) m_busy[k] = 0;
          else begin
            m_chan[k] = lowest(m_todo[k]);
            m_todo[k] = m_todo[k] & ~(3'b001 << m_chan[k]);
            m_settling[k] = 1; m_age[k] = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare plus logs of cs activity, cs-to-valid latency and accepted beats.
  int  cyc = 0;
  int  cs_cnt [2], cs_rise [2], lat [2], bcnt [2];
  int  blog [2][64];
  bit  prev_cs [2], prev_v [2];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, 32'(o_busy[k]), 32'(m_busy[k]));
        chk("cs", k, 32'(o_cs[k]), 32'(m_busy[k] && m_settling[k]));
        chk("sel", k, 32'(o_sel[k]), 32'(m_chan[k]));
        chk("out_valid", k, 32'(o_valid[k]), 32'(m_ov[k]));
        chk("out_data", k, 32'(o_data[k]), 32'(m_od[k]));
        chk("out_chan", k, 32'(o_chan[k]), 32'(m_oc[k]));
        chk("out_last", k, 32'(o_last[k]), 32'(m_ol[k]));
        chk("alpha", k, 32'(o_alpha[k]), 32'(m_reg[k][0]));
        chk("beta", k, 32'(o_beta[k]), 32'(m_reg[k][1]));
        chk("gamma", k, 32'(o_gamma[k]), 32'(m_reg[k][2]));
        if (o_cs[k]) cs_cnt[k]++;
        if (o_cs[k] && !prev_cs[k]) cs_rise[k] = cyc;
        if (o_valid[k] && !prev_v[k]) lat[k] = cyc - cs_rise[k];
        prev_cs[k] = o_cs[k];
        prev_v[k]  = o_valid[k];
        if (o_valid[k] && rdy[k] && !reset && bcnt[k] < 64) begin
          blog[k][bcnt[k]] = int'(o_last[k]) * 1024 + int'(o_chan[k]) * 256 + int'(o_data[k]);
          bcnt[k]++;
        end
      end
    end
  end

  // Downstream: either always ready, or holds each beat off for stall_n cycles.
  bit tie_ready = 1;
  int stall_n   = 0;
  int wc [2];

  initial begin
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (tie_ready) rdy[k] = 1'b1;
        else if (!o_valid[k]) begin rdy[k] = 1'b0; wc[k] = 0; end
        else if (wc[k] < stall_n) begin rdy[k] = 1'b0; wc[k]++; end
        else rdy[k] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] m);
    start = 1'b1; chan_mask = m;
    tick();
    start = 1'b0; chan_mask = 3'b000;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((o_busy[0] || o_busy[1]) && n < 300) begin tick(); n++; end
    chk(tag, 0, 32'(n >= 300), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!(o_valid[0] && o_valid[1]) && n < 50) begin tick(); n++; end
    chk(tag, 0, 32'(n >= 50), 32'd0);
  endtask

  task automatic chk_beat(input string tag, input int k, input int idx, input int exp);
    chk(tag, k, (idx < bcnt[k]) ? blog[k][idx] : -1, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_busy"}, k, 32'(o_busy[k]), 32'd0);
      chk({tag, "_cs"}, k, 32'(o_cs[k]), 32'd0);
      chk({tag, "_valid"}, k, 32'(o_valid[k]), 32'd0);
      chk({tag, "_data"}, k, 32'(o_data[k]), 32'd0);
      chk({tag, "_alpha"}, k, 32'(o_alpha[k]), 32'd0);
      chk({tag, "_gamma"}, k, 32'(o_gamma[k]), 32'd0);
      chk({tag, "_sel"}, k, 32'(o_sel[k]), 32'd0);
    end
  endtask

  int b0 [2], c0 [2];

  task automatic snap();
    for (int k = 0; k < 2; k++) begin b0[k] = bcnt[k]; c0[k] = cs_cnt[k]; end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; start = 1'b0; chan_mask = 3'b000;
    tick(); tick();
    reset = 1'b0;
    chk_zero_outputs("reset");

    // Register load and single channel
    write(2'd0, 8'h11); write(2'd1, 8'h22); write(2'd2, 8'h33);
    snap();
    pulse_start(3'b010);
    wait_idle("t1_idle");
    chk("t1_cs_cycles", 0, cs_cnt[0] - c0[0], 1);
    chk("t1_cs_cycles", 1, cs_cnt[1] - c0[1], 3);
    for (int k = 0; k < 2; k++) begin
      chk("t1_nbeats", k, bcnt[k] - b0[k], 1);
      chk_beat("t1_beat", k, b0[k], 'h522);
    end

    // Full scan with backpressure
    tie_ready = 0; stall_n = 3;
    snap();
    pulse_start(3'b111);
    wait_idle("t2_idle");
    for (int k = 0; k < 2; k++) begin
      chk("t2_nbeats", k, bcnt[k] - b0[k], 3);
      chk_beat("t2_beat0", k, b0[k], 'h011);
      chk_beat("t2_beat1", k, b0[k] + 1, 'h122);
      chk_beat("t2_beat2", k, b0[k] + 2, 'h633);
    end

    // Sparse mask: channel 1 skipped, cs-to-valid latency equals the settle time
    tie_ready = 1; stall_n = 0;
    snap();
    pulse_start(3'b101);
    wait_idle("t3_idle");
    chk("t3_cs_cycles", 0, cs_cnt[0] - c0[0], 2);
    chk("t3_cs_cycles", 1, cs_cnt[1] - c0[1], 6);
    chk("t3_latency", 0, lat[0], 1);
    chk("t3_latency", 1, lat[1], 3);
    for (int k = 0; k < 2; k++) begin
      chk("t3_nbeats", k, bcnt[k] - b0[k], 2);
      chk_beat("t3_beat0", k, b0[k], 'h011);
      chk_beat("t3_beat1", k, b0[k] + 1, 'h633);
    end

    // Ignored inputs
    pulse_start(3'b000);
    chk("t4_mask0_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("t4_mask0_busy", 1, 32'(o_busy[1]), 32'd0);
    write(2'd3, 8'hEE);
    chk("t4_noop_alpha", 0, 32'(o_alpha[0]), 32'h11);
    chk("t4_noop_beta", 1, 32'(o_beta[1]), 32'h22);
    chk("t4_noop_gamma", 0, 32'(o_gamma[0]), 32'h33);
    tie_ready = 0; stall_n = 3;
    snap();
    pulse_start(3'b111);
    write(2'd0, 8'h99);
    pulse_start(3'b001);
    write(2'd2, 8'h77);
    wait_idle("t4_idle");
    for (int k = 0; k < 2; k++) begin
      chk("t4_alpha_kept", k, 32'(o_alpha[k]), 32'h11);
      chk("t4_gamma_kept", k, 32'(o_gamma[k]), 32'h33);
      chk("t4_nbeats", k, bcnt[k] - b0[k], 3);
      chk_beat("t4_beat0", k, b0[k], 'h011);
      chk_beat("t4_beat2", k, b0[k] + 2, 'h633);
    end
    tick();
    chk("t4_no_restart", 0, 32'(o_busy[0]), 32'd0);

    // Reset while settling
    tie_ready = 1; stall_n = 0;
    pulse_start(3'b111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero_outputs("t5_settle_rst");

    // Reset while holding a valid result
    write(2'd0, 8'h44); write(2'd1, 8'h55); write(2'd2, 8'h66);
    tie_ready = 0; stall_n = 100;
    pulse_start(3'b111);
    wait_valid("t5_hold_wait");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero_outputs("t5_hold_rst");
    stall_n = 0; tie_ready = 1;
    snap();
    pulse_start(3'b001);
    wait_idle("t5_idle");
    for (int k = 0; k < 2; k++) begin
      chk("t5_nbeats", k, bcnt[k] - b0[k], 1);
      chk_beat("t5_beat", k, b0[k], 'h400);
    end

    // Same-edge write and start
    snap();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; start = 1'b1; chan_mask = 3'b100;
    tick();
    wr_en = 1'b0; start = 1'b0; chan_mask = 3'b000;
    wait_idle("t6_idle");
    for (int k = 0; k < 2; k++) begin
      chk("t6_gamma", k, 32'(o_gamma[k]), 32'hA5);
      chk("t6_nbeats", k, bcnt[k] - b0[k], 1);
      chk_beat("t6_beat", k, b0[k], 'h6A5);
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
